aes_key_load_ctrl: RTL and testbench
====================================

Name: aes_key_load_ctrl

Overview:
- Sequences loading of the AES-256 key.
- Accepts 32-bit key/seed words over a valid/ready stream and packs 8 of them into a 256-bit key register.
- Fires a one-cycle start pulse at the key-expansion engine, then waits for its done before declaring the key usable.
- Sits between the host-side word stream and the key-schedule/round datapath; it owns key_out and gates all key reloads.

Parameters:
- DATA_W, 32, width of one input word.
- WORDS, 8, words per key; key width is DATA_W*WORDS = 256.
- CNT_W, 4, width of word_cnt; must hold the value WORDS.
- TIMEOUT_CYC, 64, expansion watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  DATA_W  input key word.
- flush  in  1  synchronous abort; discards partial or complete key.
- key_out  out  DATA_W*WORDS  assembled key to the expansion engine.
- key_start  out  1  one-cycle pulse requesting key expansion.
- key_done  in  1  expansion engine finished (pulse or level).
- key_valid  out  1  key expanded and usable by the round datapath.
- key_busy  out  1  high in START or EXPAND.
- word_cnt  out  CNT_W  words accepted for the current key, 0..WORDS.
- err  out  1  expansion timeout flag.

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous, active-low.
- While resetn is low: state=IDLE, key_out=0, word_cnt=0, key_valid=0, key_start=0, err=0, s_ready=0.
- States: IDLE, LOAD, START, EXPAND, READY, plus ERROR when the optional feature is compiled in.
- Handshake:
  - A word is accepted on a clk edge where s_valid and s_ready are both high.
  - s_ready = state in {IDLE, LOAD, READY} and not flush. Combinational; no dependence on s_valid.
- Packing:
  - The word accepted with word_cnt=i is written to key_out[i*DATA_W +: DATA_W].
  - Word 0 occupies the LSBs.
  - Unwritten slots hold their previous value.
- Counting: word_cnt increments by 1 per accepted word.
- IDLE: on accept, write slot 0, word_cnt=1, go to LOAD.
- LOAD:
  - On accept with word_cnt<WORDS-1, stay in LOAD.
  - On accept with word_cnt=WORDS-1, write the last slot, word_cnt=WORDS, go to START.
- START:
  - key_start=1 for exactly this one cycle; go to EXPAND.
  - key_out is frozen from START until READY is left.
- EXPAND:
  - key_start=0; wait for key_done=1, then go to READY with key_valid=1 on the same edge.
  - key_done is ignored in every other state.
- READY:
  - key_valid=1 and word_cnt=WORDS hold.
  - A new accept starts a reload: the word goes to slot 0, word_cnt=1, key_valid=0 on that edge, go to LOAD.
- Output latency: key_valid rises 1 cycle after key_done is sampled. key_start rises 1 cycle after the last word is accepted.
- flush:
  - Sampled on a clk edge, it has priority over everything except reset.
  - Result: state=IDLE, word_cnt=0, key_out=0, key_valid=0, err=0.
  - A word presented in the same cycle is not accepted, because s_ready is low.
  - flush in START or EXPAND abandons the engine; a late key_done is ignored.
- key_busy = state in {START, EXPAND}, decoded from the state register.
- key_start is decoded from the state register: glitch-free, exactly one cycle per key.

Optional Feature:
- Macro: KEY_LOAD_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to EXPAND and increments each EXPAND cycle.
  - If TIMEOUT_CYC cycles elapse in EXPAND with no key_done, go to ERROR with err=1, s_ready=0, key_valid=0, key_busy=0.
  - ERROR is left only by flush or reset.
  - If key_done coincides with the timeout cycle, key_done wins and the state goes to READY.
- Not defined:
  - No counter and no ERROR state; EXPAND waits indefinitely.
  - err is tied to 0.

Test Plan:
- Reset, then 8 words 0x00000001..0x00000008 with s_valid held high:
  - key_out = 0x00000008_00000007_..._00000001; word_cnt steps 1..8.
  - key_start pulses once 1 cycle after the 8th accept; s_ready=0 during START/EXPAND.
  - key_done 5 cycles later -> key_valid=1 on the next edge.
- Load 3 words, assert flush for 1 cycle with s_valid=1 -> word not accepted; word_cnt=0, key_out=0, state IDLE; a fresh 8-word load then completes normally.
- In READY, send word 0xDEADBEEF:
  - key_valid drops on the accept edge; word_cnt=1; key_out[31:0]=0xDEADBEEF; upper slots unchanged.
  - A further 7 words plus key_done -> key_valid=1.
- Pulse key_done while in IDLE and in LOAD -> no state change, key_valid stays 0; flush during EXPAND followed by a late key_done -> remains IDLE.
- Toggle s_valid randomly during a load (gaps of 0-3 cycles) -> exactly 8 accepts, correct packing, a single key_start.
- With KEY_LOAD_TIMEOUT_EN and TIMEOUT_CYC=64:
  - No key_done -> err=1 after 64 EXPAND cycles; s_ready=0 until flush.
  - Repeat with key_done on exactly cycle 64 -> READY, err=0.

Source files
------------

// File: rtl/aes_key_load_ctrl.sv
// AES-256 key load sequencer: packs WORDS input words into key_out, then handshakes with the key-expansion engine.
// Optional expansion watchdog and ERROR state enabled by defining KEY_LOAD_TIMEOUT_EN.
`timescale 1ns/1ps

module aes_key_load_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WORDS       = 8,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    flush,
    output logic [DATA_W*WORDS-1:0] key_out,
    output logic                    key_start,
    input  logic                    key_done,
    output logic                    key_valid,
    output logic                    key_busy,
    output logic [CNT_W-1:0]        word_cnt,
    output logic                    err
);

    localparam int unsigned KEY_W = DATA_W * WORDS;

    // Reject configurations where word_cnt cannot reach WORDS or the watchdog is zero.
    if (CNT_W < $clog2(WORDS + 1) || TIMEOUT_CYC == 0) begin : g_param_check
        $error("aes_key_load_ctrl: invalid CNT_W or TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_EXPAND = 3'd3,
`ifdef KEY_LOAD_TIMEOUT_EN
        ST_READY  = 3'd4,
        ST_ERROR  = 3'd5
`else
        ST_READY  = 3'd4
`endif
    } state_t;

    state_t             state_q;
    logic [KEY_W-1:0]   key_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               valid_q;
    logic               accept;
    logic               last_word;
    state_t             first_state;

`ifdef KEY_LOAD_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0]   tmr_q;
    logic               err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Ready depends only on the state register and flush, never on s_valid.
    assign s_ready     = resetn && !flush &&
                         (state_q == ST_IDLE || state_q == ST_LOAD || state_q == ST_READY);
    assign accept      = s_valid && s_ready;
    assign last_word   = (cnt_q == CNT_W'(WORDS - 1));
    assign first_state = (WORDS == 1) ? ST_START : ST_LOAD;

    assign key_out   = key_q;
    assign word_cnt  = cnt_q;
    assign key_valid = valid_q;
    assign key_start = (state_q == ST_START);
    assign key_busy  = (state_q == ST_START) || (state_q == ST_EXPAND);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef KEY_LOAD_TIMEOUT_EN
            tmr_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else if (flush) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef KEY_LOAD_TIMEOUT_EN
            tmr_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                // A first word (fresh load or reload from READY) always lands in slot 0.
                ST_IDLE, ST_READY: begin
                    if (accept) begin
                        key_q[DATA_W-1:0] <= s_data;
                        cnt_q             <= CNT_W'(1);
                        valid_q           <= 1'b0;
                        state_q           <= first_state;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        for (int unsigned i = 0; i < WORDS; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                key_q[i*DATA_W +: DATA_W] <= s_data;
                            end
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_word) begin
                            state_q <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    state_q <= ST_EXPAND;
`ifdef KEY_LOAD_TIMEOUT_EN
                    tmr_q   <= '0;
`endif
                end
                // key_done beats a coincident watchdog expiry.
                ST_EXPAND: begin
                    if (key_done) begin
                        state_q <= ST_READY;
                        valid_q <= 1'b1;
`ifdef KEY_LOAD_TIMEOUT_EN
                    end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                    end else begin
                        tmr_q   <= tmr_q + TMR_W'(1);
`endif
                    end
                end
`ifdef KEY_LOAD_TIMEOUT_EN
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_load_ctrl.sv
// Directed self-checking bench for aes_key_load_ctrl: vector table for the basic load plus hand sequences.
`timescale 1ns/1ps

module tb_aes_key_load_ctrl;

    logic         clk = 1'b0;
    logic         resetn;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         flush;
    logic [255:0] key_out;
    logic         key_start;
    logic         key_done;
    logic         key_valid;
    logic         key_busy;
    logic [3:0]   word_cnt;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic pre_ready;

    aes_key_load_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .flush     (flush),
        .key_out   (key_out),
        .key_start (key_start),
        .key_done  (key_done),
        .key_valid (key_valid),
        .key_busy  (key_busy),
        .word_cnt  (word_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        f;
        logic        done;
        logic        e_ready;
        logic [3:0]  e_cnt;
        logic        e_kv;
        logic        e_start;
        logic        e_busy;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, capture combinational s_ready before the edge, then sample #1 after the edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic f, input logic done);
        s_valid  = v;
        s_data   = d;
        flush    = f;
        key_done = done;
        #1;
        pre_ready = s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string name, input logic [3:0] cnt, input logic kv,
                          input logic st, input logic busy);
        chk({name, "_cnt"},   256'(word_cnt),  256'(cnt));
        chk({name, "_kv"},    256'(key_valid), 256'(kv));
        chk({name, "_start"}, 256'(key_start), 256'(st));
        chk({name, "_busy"},  256'(key_busy),  256'(busy));
    endtask

    // Eight back-to-back words base..base+7 starting from IDLE/READY; ends in START.
    task automatic load8(input string name, input logic [31:0] base, output logic [255:0] exp_key);
        exp_key = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, base + 32'(i), 1'b0, 1'b0);
            exp_key[i*32 +: 32] = base + 32'(i);
            chk($sformatf("%s_rdy%0d", name, i), 256'(pre_ready), 256'(1));
            chk($sformatf("%s_cnt%0d", name, i), 256'(word_cnt), 256'(i + 1));
        end
        chk({name, "_start"}, 256'(key_start), 256'(1));
        chk({name, "_key"}, key_out, exp_key);
    endtask

    logic [255:0] exp_key;
    logic [255:0] key_a;
    int starts;

    initial begin
        resetn = 1'b0; s_valid = 1'b1; s_data = 32'h1; flush = 1'b0; key_done = 1'b1;
        for (int i = 0; i < 15; i++) begin
            vt[i] = '{v: 1'b1, d: 32'(i + 1), f: 1'b0, done: 1'b0,
                      e_ready: 1'b0, e_cnt: 4'd8, e_kv: 1'b0, e_start: 1'b0, e_busy: 1'b1};
            if (i < 8) begin
                vt[i].e_ready = 1'b1;
                vt[i].e_cnt   = 4'(i + 1);
                vt[i].e_busy  = (i == 7);
                vt[i].e_start = (i == 7);
            end
        end
        vt[13].done = 1'b1; vt[13].e_kv = 1'b1; vt[13].e_busy = 1'b0;
        vt[14].v = 1'b0; vt[14].done = 1'b1; vt[14].e_ready = 1'b1;
        vt[14].e_kv = 1'b1; vt[14].e_busy = 1'b0;

        // Reset values, including s_ready low while reset is held
        #12;
        chk("rst_ready", 256'(s_ready), 256'(0));
        chk("rst_key",   key_out,       256'(0));
        chk("rst_err",   256'(err),     256'(0));
        chk_st("rst", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        key_done = 1'b0; s_valid = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Basic load, START, EXPAND wait of 5 cycles, key_done, then ignored key_done in READY
        for (int i = 0; i < 15; i++) begin
            cyc(vt[i].v, vt[i].d, vt[i].f, vt[i].done);
            chk($sformatf("v%0d_rdy", i), 256'(pre_ready), 256'(vt[i].e_ready));
            chk_st($sformatf("v%0d", i), vt[i].e_cnt, vt[i].e_kv, vt[i].e_start, vt[i].e_busy);
        end
        exp_key = '0;
        for (int i = 0; i < 8; i++) exp_key[i*32 +: 32] = 32'(i + 1);
        chk("tbl_key", key_out, exp_key);

        // Reload from READY: slot 0 replaced, upper slots kept, key_valid drops on accept edge
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        exp_key[31:0] = 32'hDEADBEEF;
        chk("rl_key0", key_out, exp_key);
        chk_st("rl_first", 4'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
            exp_key[i*32 +: 32] = 32'h10 + 32'(i);
        end
        chk("rl_key", key_out, exp_key);
        chk_st("rl_start", 4'd8, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk_st("rl_ready", 4'd8, 1'b1, 1'b0, 1'b0);

        // Flush with s_valid high from READY
        cyc(1'b1, 32'h55, 1'b1, 1'b0);
        chk("fl0_rdy", 256'(pre_ready), 256'(0));
        chk("fl0_key", key_out, 256'(0));
        chk_st("fl0", 4'd0, 1'b0, 1'b0, 1'b0);

        // Three words, flush, then a fresh complete load
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        chk("p3_cnt", 256'(word_cnt), 256'(3));
        cyc(1'b1, 32'hA3, 1'b1, 1'b0);
        chk("fl1_rdy", 256'(pre_ready), 256'(0));
        chk("fl1_key", key_out, 256'(0));
        chk_st("fl1", 4'd0, 1'b0, 1'b0, 1'b0);
        load8("fresh", 32'hC0, key_a);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk_st("fresh_rdy", 4'd8, 1'b1, 1'b0, 1'b0);
        chk("fresh_key", key_out, key_a);

        // key_done in IDLE and LOAD has no effect
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk_st("done_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        chk("done_idle_rdy", 256'(s_ready), 256'(1));
        cyc(1'b1, 32'h1, 1'b0, 1'b0);
        cyc(1'b1, 32'h2, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk_st("done_load", 4'd2, 1'b0, 1'b0, 1'b0);

        // Flush during EXPAND, then a late key_done is ignored
        for (int i = 2; i < 8; i++) cyc(1'b1, 32'(i + 1), 1'b0, 1'b0);
        chk_st("fe_start", 4'd8, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk_st("fe_exp", 4'd8, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk_st("fe_late", 4'd0, 1'b0, 1'b0, 1'b0);
        chk("fe_key", key_out, 256'(0));

        // Gappy s_valid: exactly 8 accepts, correct packing, one key_start
        exp_key = '0;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                cyc(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
                if (key_start) starts++;
            end
            cyc(1'b1, 32'h3000 + 32'(i * 7), 1'b0, 1'b0);
            exp_key[i*32 +: 32] = 32'h3000 + 32'(i * 7);
            if (key_start) starts++;
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'hBAD0, 1'b0, 1'b0);
            if (key_start) starts++;
        end
        chk("gap_starts", 256'(starts), 256'(1));
        chk("gap_key", key_out, exp_key);
        chk_st("gap_exp", 4'd8, 1'b0, 1'b0, 1'b1);
        chk("gap_err", 256'(err), 256'(0));

`ifdef KEY_LOAD_TIMEOUT_EN
        // Watchdog expiry: 64 EXPAND cycles with no key_done
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        load8("to", 32'h700, key_a);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("to_pre_err", 256'(err), 256'(0));
        chk("to_pre_busy", 256'(key_busy), 256'(1));
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("to_err", 256'(err), 256'(1));
        chk_st("to", 4'd8, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1, 1'b0, 1'b1);
        chk("to_hold_rdy", 256'(pre_ready), 256'(0));
        chk("to_hold_err", 256'(err), 256'(1));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("to_flush_err", 256'(err), 256'(0));
        chk("to_flush_rdy", 256'(s_ready), 256'(1));
        // key_done on the 64th EXPAND cycle wins
        load8("tw", 32'h800, key_a);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("tw_err", 256'(err), 256'(0));
        chk_st("tw", 4'd8, 1'b1, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
